settings_batch_handler: RTL

Parametrised successor to the single-record settings loader. On `start` it reads up to `MAX_REC` command records from the settings buffer RAM, each one command byte plus `DATA_BYTES` little-endian data bytes. It validates each record, stages the results, and applies all staged values in one atomic commit. It sits between the UART/buffer RAM front end and the settings register consumers (matrix generator, range checker, countdown timer), and adds error reporting with a clear-without-reset path.

---
 rtl/settings_pkg.sv | 50 +++++
 rtl/settings_record_check.sv | 68 ++++++
 rtl/settings_batch_handler.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/settings_pkg.sv
// rtl/settings_pkg.sv - shared command/error encodings and default limits for the settings block
package settings_pkg;

    // Command byte values carried in byte 0 of each record
    typedef enum logic [7:0] {
        CMD_MAX_ROW   = 8'd1,
        CMD_MAX_COL   = 8'd2,
        CMD_DATA_MIN  = 8'd3,
        CMD_DATA_MAX  = 8'd4,
        CMD_COUNTDOWN = 8'd5
    } cmd_e;

    // Reported failure cause
    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_BAD_CMD   = 3'd1,
        ERR_RANGE     = 3'd2,
        ERR_ORDER     = 3'd3,
        ERR_BAD_COUNT = 3'd4
    } err_code_e;

    // Which staged setting a validated record writes
    typedef enum logic [2:0] {
        TGT_NONE      = 3'd0,
        TGT_MAX_ROW   = 3'd1,
        TGT_MAX_COL   = 3'd2,
        TGT_DATA_MIN  = 3'd3,
        TGT_DATA_MAX  = 3'd4,
        TGT_COUNTDOWN = 3'd5
    } target_e;

    // Batch sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_COMMIT = 3'd4,
        ST_FAIL   = 3'd5
    } state_e;

    // Defaults and limits shared with the settings consumers
    localparam int DEF_DATA_BYTES     = 4;
    localparam int DEF_MAX_REC        = 8;
    localparam int DEF_MAX_DIM        = 32;
    localparam int DEF_DATA_MAX_LIMIT = 65535;
    localparam int DEF_CD_MIN         = 5;
    localparam int DEF_CD_MAX         = 15;

endpackage

// File: rtl/settings_record_check.sv
// rtl/settings_record_check.sv - combinational validation of one {cmd, data} settings record
module settings_record_check
    import settings_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int MAX_DIM        = DEF_MAX_DIM,
    parameter int DATA_MAX_LIMIT = DEF_DATA_MAX_LIMIT,
    parameter int CD_MIN         = DEF_CD_MIN,
    parameter int CD_MAX         = DEF_CD_MAX
) (
    input  logic [7:0]        cmd_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              pass_o,
    output err_code_e         err_code_o,
    output target_e           target_o
);

    localparam logic [DATA_W-1:0]        DIM_HI = DATA_W'(MAX_DIM);
    localparam logic signed [DATA_W-1:0] DMAX   = DATA_W'(DATA_MAX_LIMIT);
    localparam logic [DATA_W-1:0]        CD_LO  = DATA_W'(CD_MIN);
    localparam logic [DATA_W-1:0]        CD_HI  = DATA_W'(CD_MAX);

    logic range_ok;

    // Decode the command, pick its target and apply that command's legal range
    always_comb begin
        range_ok = 1'b0;
        target_o = TGT_NONE;
        case (cmd_i)
            CMD_MAX_ROW: begin
                target_o = TGT_MAX_ROW;
                range_ok = (data_i != '0) && (data_i <= DIM_HI);
            end
            CMD_MAX_COL: begin
                target_o = TGT_MAX_COL;
                range_ok = (data_i != '0) && (data_i <= DIM_HI);
            end
            CMD_DATA_MIN: begin
                target_o = TGT_DATA_MIN;
                range_ok = 1'b1;
            end
            CMD_DATA_MAX: begin
                target_o = TGT_DATA_MAX;
                range_ok = ($signed(data_i) <= DMAX);
            end
            CMD_COUNTDOWN: begin
                target_o = TGT_COUNTDOWN;
                range_ok = (data_i >= CD_LO) && (data_i <= CD_HI);
            end
            default: begin
                target_o = TGT_NONE;
                range_ok = 1'b0;
            end
        endcase
    end

    // Unknown commands report BAD_CMD; known ones report RANGE when out of bounds
    always_comb begin
        pass_o     = (target_o != TGT_NONE) && range_ok;
        err_code_o = ERR_NONE;
        if (target_o == TGT_NONE) begin
            err_code_o = ERR_BAD_CMD;
        end else if (!range_ok) begin
            err_code_o = ERR_RANGE;
        end
    end

endmodule

// File: rtl/settings_batch_handler.sv
// rtl/settings_batch_handler.sv - reads, validates, stages and atomically commits a batch of settings records
module settings_batch_handler
    import settings_pkg::*;
#(
    parameter int DATA_BYTES     = DEF_DATA_BYTES,
    parameter int MAX_REC        = DEF_MAX_REC,
    parameter int MAX_DIM        = DEF_MAX_DIM,
    parameter int DATA_MAX_LIMIT = DEF_DATA_MAX_LIMIT,
    parameter int CD_MIN         = DEF_CD_MIN,
    parameter int CD_MAX         = DEF_CD_MAX,
    localparam int DATA_W        = 8 * DATA_BYTES,
    localparam int RCW           = $clog2(MAX_REC + 1),
    localparam int IW            = (MAX_REC > 1) ? $clog2(MAX_REC) : 1,
    localparam int AW            = $clog2(MAX_REC * (DATA_BYTES + 1))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RCW-1:0]    rec_count,
    input  logic              err_clr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        err_code,
    output logic [IW-1:0]     err_index,
    output logic              ram_rd_en,
    output logic [AW-1:0]     ram_rd_addr,
    input  logic [7:0]        ram_rd_data,
    output logic              settings_wr_en,
    output logic [DATA_W-1:0] settings_max_row,
    output logic [DATA_W-1:0] settings_max_col,
    output logic [DATA_W-1:0] settings_data_min,
    output logic [DATA_W-1:0] settings_data_max,
    output logic [DATA_W-1:0] settings_countdown_time
);

    localparam int BW = $clog2(DATA_BYTES + 1);
    localparam logic [DATA_W-1:0] RST_DIM = DATA_W'(MAX_DIM);
    localparam logic [DATA_W-1:0] RST_MIN = '0;
    localparam logic [DATA_W-1:0] RST_MAX = DATA_W'(DATA_MAX_LIMIT);
    localparam logic [DATA_W-1:0] RST_CD  = DATA_W'(CD_MAX);

    state_e            state_q;
    logic              busy_q, done_q, wr_en_q, error_q, commit_ok_q;
    err_code_e         err_code_q;
    logic [IW-1:0]     err_index_q;
    logic              rd_en_q;
    logic [AW-1:0]     rd_addr_q;
    logic [BW-1:0]     byte_q;
    logic [IW-1:0]     rec_q;
    logic [RCW-1:0]    rec_total_q;
    logic [7:0]        cmd_q;
    logic [DATA_W-1:0] data_q;

    // Staged values (built up during the batch) and live settings
    logic [DATA_W-1:0] stg_row_q, stg_col_q, stg_min_q, stg_max_q, stg_cd_q;
    logic [DATA_W-1:0] stg_row_d, stg_col_d, stg_min_d, stg_max_d, stg_cd_d;
    logic [DATA_W-1:0] set_row_q, set_col_q, set_min_q, set_max_q, set_cd_q;

    logic              chk_pass;
    err_code_e         chk_code;
    target_e           chk_target;
    logic              stg_order_ok, cur_order_ok, last_rec;
    logic [DATA_W-1:0] data_shifted;

    settings_record_check #(
        .DATA_W         (DATA_W),
        .MAX_DIM        (MAX_DIM),
        .DATA_MAX_LIMIT (DATA_MAX_LIMIT),
        .CD_MIN         (CD_MIN),
        .CD_MAX         (CD_MAX)
    ) u_check (
        .cmd_i      (cmd_q),
        .data_i     (data_q),
        .pass_o     (chk_pass),
        .err_code_o (chk_code),
        .target_o   (chk_target)
    );

    // Data bytes arrive LSB first, so shifting in from the top leaves byte 1 at bit 0
    assign data_shifted = DATA_W'({ram_rd_data, data_q} >> 8);
    assign last_rec     = (RCW'(rec_q) + RCW'(1)) == rec_total_q;
    assign cur_order_ok = $signed(set_min_q) <= $signed(set_max_q);
    assign stg_order_ok = $signed(stg_min_d) <= $signed(stg_max_d);

    // Staging view with the record under check folded in; duplicates overwrite so the last wins
    always_comb begin
        stg_row_d = stg_row_q;
        stg_col_d = stg_col_q;
        stg_min_d = stg_min_q;
        stg_max_d = stg_max_q;
        stg_cd_d  = stg_cd_q;
        case (chk_target)
            TGT_MAX_ROW:   stg_row_d = data_q;
            TGT_MAX_COL:   stg_col_d = data_q;
            TGT_DATA_MIN:  stg_min_d = data_q;
            TGT_DATA_MAX:  stg_max_d = data_q;
            TGT_COUNTDOWN: stg_cd_d  = data_q;
            default:       stg_row_d = stg_row_q;
        endcase
    end

    // Batch sequencer with registered outputs; the commit decision is taken on the edge
    // leaving the last CHECK so that done and the new values appear in the COMMIT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            error_q     <= 1'b0;
            commit_ok_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_index_q <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            byte_q      <= '0;
            rec_q       <= '0;
            rec_total_q <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            stg_row_q   <= RST_DIM;
            stg_col_q   <= RST_DIM;
            stg_min_q   <= RST_MIN;
            stg_max_q   <= RST_MAX;
            stg_cd_q    <= RST_CD;
            set_row_q   <= RST_DIM;
            set_col_q   <= RST_DIM;
            set_min_q   <= RST_MIN;
            set_max_q   <= RST_MAX;
            set_cd_q    <= RST_CD;
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (err_clr) begin
                        error_q     <= 1'b0;
                        err_code_q  <= ERR_NONE;
                        err_index_q <= '0;
                    end else if (start && !error_q) begin
                        stg_row_q   <= set_row_q;
                        stg_col_q   <= set_col_q;
                        stg_min_q   <= set_min_q;
                        stg_max_q   <= set_max_q;
                        stg_cd_q    <= set_cd_q;
                        rec_q       <= '0;
                        rec_total_q <= rec_count;
                        if (rec_count == '0) begin
                            state_q     <= ST_COMMIT;
                            commit_ok_q <= cur_order_ok;
                            done_q      <= cur_order_ok;
                        end else if (rec_count > RCW'(MAX_REC)) begin
                            state_q     <= ST_FAIL;
                            error_q     <= 1'b1;
                            err_code_q  <= ERR_BAD_COUNT;
                            err_index_q <= '0;
                        end else begin
                            state_q   <= ST_READ;
                            busy_q    <= 1'b1;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= '0;
                            byte_q    <= '0;
                        end
                    end
                end
                ST_READ: begin
                    if (byte_q == BW'(1)) begin
                        cmd_q <= ram_rd_data;
                    end else if (byte_q > BW'(1)) begin
                        data_q <= data_shifted;
                    end
                    if (byte_q == BW'(DATA_BYTES)) begin
                        state_q <= ST_WAIT;
                        rd_en_q <= 1'b0;
                    end else begin
                        byte_q    <= byte_q + BW'(1);
                        rd_addr_q <= rd_addr_q + AW'(1);
                    end
                end
                ST_WAIT: begin
                    data_q  <= data_shifted;
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (!chk_pass) begin
                        state_q     <= ST_FAIL;
                        busy_q      <= 1'b0;
                        error_q     <= 1'b1;
                        err_code_q  <= chk_code;
                        err_index_q <= rec_q;
                    end else begin
                        stg_row_q <= stg_row_d;
                        stg_col_q <= stg_col_d;
                        stg_min_q <= stg_min_d;
                        stg_max_q <= stg_max_d;
                        stg_cd_q  <= stg_cd_d;
                        if (last_rec) begin
                            state_q     <= ST_COMMIT;
                            commit_ok_q <= stg_order_ok;
                            if (stg_order_ok) begin
                                done_q    <= 1'b1;
                                wr_en_q   <= 1'b1;
                                busy_q    <= 1'b0;
                                set_row_q <= stg_row_d;
                                set_col_q <= stg_col_d;
                                set_min_q <= stg_min_d;
                                set_max_q <= stg_max_d;
                                set_cd_q  <= stg_cd_d;
                            end
                        end else begin
                            state_q   <= ST_READ;
                            rec_q     <= rec_q + IW'(1);
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= rd_addr_q + AW'(1);
                            byte_q    <= '0;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (commit_ok_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q     <= ST_FAIL;
                        busy_q      <= 1'b0;
                        error_q     <= 1'b1;
                        err_code_q  <= ERR_ORDER;
                        err_index_q <= '0;
                    end
                end
                ST_FAIL: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy                    = busy_q;
    assign done                    = done_q;
    assign error                   = error_q;
    assign err_code                = err_code_q;
    assign err_index               = err_index_q;
    assign ram_rd_en               = rd_en_q;
    assign ram_rd_addr             = rd_addr_q;
    assign settings_wr_en          = wr_en_q;
    assign settings_max_row        = set_row_q;
    assign settings_max_col        = set_col_q;
    assign settings_data_min       = set_min_q;
    assign settings_data_max       = set_max_q;
    assign settings_countdown_time = set_cd_q;

endmodule
